// File: rtl/mem_access_unit.sv
// mem_access_unit: runs the data-memory transaction for the instruction held in
// EX/MEM. It builds byte enables and lane-replicated store data, waits on a
// req/ready handshake with a timeout, extends load data, and registers the
// result into MEM/WB. Upstream stages are stalled while a request is in flight.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [2:0]  in_f3,
  input  logic [31:0] in_aluresult,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_aluresult,
  output logic [31:0] wb_loaddata,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  // Copy of the instruction taken on the IDLE->BUSY edge
  logic        lat_regwrite_reg;
  logic        lat_memtoreg_reg;
  logic        lat_memread_reg;
  logic [2:0]  lat_f3_reg;
  logic [4:0]  lat_rd_reg;
  logic [31:0] lat_alu_reg;

  logic        mem_op;
  logic        legal;
  logic        accept;
  logic        done_ok;
  logic        done_to;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign mem_op = in_valid & (in_memread | in_memwrite);

  // Decode the incoming access: legality, byte enables, lane-replicated data
  always_comb begin
    legal      = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = 32'h0;
    if (!(in_memread && in_memwrite)) begin
      case (in_f3)
        3'b000, 3'b100: begin
          legal      = 1'b1;
          be_calc    = 4'b0001 << in_aluresult[1:0];
          wdata_calc = {4{in_store_data[7:0]}};
        end
        3'b001, 3'b101: begin
          legal      = ~in_aluresult[0];
          be_calc    = in_aluresult[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{in_store_data[15:0]}};
        end
        3'b010: begin
          legal      = (in_aluresult[1:0] == 2'b00);
          be_calc    = 4'b1111;
          wdata_calc = in_store_data;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Pick the addressed lane of the returned word and extend it per funct3
  always_comb begin
    case (lat_alu_reg[1:0])
      2'b00:   lane_byte = dmem_rdata[7:0];
      2'b01:   lane_byte = dmem_rdata[15:8];
      2'b10:   lane_byte = dmem_rdata[23:16];
      default: lane_byte = dmem_rdata[31:24];
    endcase
    lane_half = lat_alu_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_f3_reg)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'h0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'h0, lane_half};
      3'b010:  load_ext = dmem_rdata;
      default: load_ext = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state, stall and transaction events; ready beats a same-cycle timeout
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op && legal) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus signals, latched instruction, timeout counter and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg          <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= 32'h0;
      dmem_be          <= 4'b0000;
      dmem_wdata       <= 32'h0;
      lat_regwrite_reg <= 1'b0;
      lat_memtoreg_reg <= 1'b0;
      lat_memread_reg  <= 1'b0;
      lat_f3_reg       <= 3'b000;
      lat_rd_reg       <= 5'd0;
      lat_alu_reg      <= 32'h0;
      wb_valid         <= 1'b0;
      wb_regwrite      <= 1'b0;
      wb_memtoreg      <= 1'b0;
      wb_rd            <= 5'd0;
      wb_aluresult     <= 32'h0;
      wb_loaddata      <= 32'h0;
      misalign         <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (accept) begin
            dmem_req         <= 1'b1;
            dmem_we          <= in_memwrite;
            dmem_addr        <= {in_aluresult[31:2], 2'b00};
            dmem_be          <= be_calc;
            dmem_wdata       <= wdata_calc;
            lat_regwrite_reg <= in_regwrite;
            lat_memtoreg_reg <= in_memtoreg;
            lat_memread_reg  <= in_memread;
            lat_f3_reg       <= in_f3;
            lat_rd_reg       <= in_rd;
            lat_alu_reg      <= in_aluresult;
            wb_valid         <= 1'b0;
            wb_regwrite      <= 1'b0;
            wb_memtoreg      <= 1'b0;
            wb_rd            <= 5'd0;
            wb_aluresult     <= 32'h0;
            wb_loaddata      <= 32'h0;
          end else if (in_valid) begin
            // Non-memory op passes through; an illegal access retires without writeback
            wb_valid     <= 1'b1;
            wb_regwrite  <= in_regwrite & ~mem_op;
            wb_memtoreg  <= in_memtoreg;
            wb_rd        <= in_rd;
            wb_aluresult <= in_aluresult;
            wb_loaddata  <= 32'h0;
            misalign     <= mem_op;
          end else begin
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= 5'd0;
            wb_aluresult <= 32'h0;
            wb_loaddata  <= 32'h0;
          end
        end
        BUSY: begin
          if (done_ok || done_to) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_be      <= 4'b0000;
            wb_valid     <= 1'b1;
            wb_regwrite  <= lat_regwrite_reg & done_ok;
            wb_memtoreg  <= lat_memtoreg_reg;
            wb_rd        <= lat_rd_reg;
            wb_aluresult <= lat_alu_reg;
            wb_loaddata  <= (done_ok && lat_memread_reg) ? load_ext : 32'h0;
            bus_err      <= done_to;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer of the EX/MEM pipeline register in the 5-stage RV32I core.
- Takes the latched memory-control bits, ALU address, store data and funct3, and runs the data-memory transaction over a req/ready handshake.
- Generates byte enables and lane-aligned store data, and sign/zero-extends load data.
- Stalls the upstream pipeline while a transaction is in flight, then registers the result into the MEM/WB boundary.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in BUSY waiting for dmem_ready before abort (min 1)
CNT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  EX/MEM slot holds a real instruction
in_regwrite  in  1  latched regwrite
in_memtoreg  in  1  latched memtoreg
in_memread  in  1  load
in_memwrite  in  1  store
in_f3  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_aluresult  in  32  effective address / ALU result
in_store_data  in  32  rs2 value (bmux result)
in_rd  in  5  destination register
stall  out  1  hold EX/MEM and earlier stages
dmem_req  out  1  transaction request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address: in_aluresult with [1:0] forced to 00
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ready  in  1  memory completes transaction this cycle
dmem_rdata  in  32  read word, valid when dmem_ready
wb_valid  out  1  MEM/WB slot valid
wb_regwrite  out  1  to WB
wb_memtoreg  out  1  to WB
wb_rd  out  5  to WB
wb_aluresult  out  32  to WB
wb_loaddata  out  32  extended load value
misalign  out  1  one-cycle pulse on misaligned or illegal access
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: all wb_* = 0, dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0, misalign = 0, bus_err = 0, counter = 0, state = IDLE.
- Reset in BUSY aborts: dmem_req is low the following cycle, and no wb update occurs.
- mem_op = in_valid & (in_memread | in_memwrite).
- Illegal access (all raise misalign; no memory request; instruction retires to WB with wb_regwrite = 0):
  - in_memread and in_memwrite both set.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Any f3 outside the five listed encodings.
- Byte enables:
  - B/BU: 0001 << addr[1:0].
  - H/HU: addr[1] ? 1100 : 0011.
  - W: 1111.
- Store data: B replicates byte[7:0] into all 4 lanes; H replicates half[15:0] into both halves; W is passed unchanged.
- Load extraction, from the lane selected by addr[1:0]:
  - B sign-extends, BU zero-extends.
  - H sign-extends, HU zero-extends.
  - W is passed unchanged.
- FSM states are IDLE and BUSY.
  - IDLE, legal mem_op: register dmem_req = 1 and the addr/be/wdata/we values; go to BUSY; clear counter. stall = 1 combinationally in this cycle.
  - BUSY: dmem_req/addr/be/wdata/we are held stable. stall = ~dmem_ready. Counter increments each cycle.
  - BUSY with dmem_ready = 1:
    - dmem_req drops next cycle; next state is IDLE.
    - Next cycle wb_valid = 1 with the latched ctrl/rd/aluresult.
    - On a load, wb_loaddata = extended rdata (captured at the ready edge).
  - BUSY when counter reaches TIMEOUT_CYCLES - 1 without ready:
    - bus_err pulses; dmem_req drops; go to IDLE.
    - Instruction retires with wb_regwrite = 0; stall releases in that same cycle.
  - Ready on the timeout cycle: ready wins, with no bus_err.
- EX/MEM inputs are sampled and latched on the IDLE→BUSY edge. Upstream holds them stable under stall, but the unit uses only the latched copy.
- Non-memory instructions (in_valid & ~mem_op) pass with latency 1, with no stall. wb_loaddata = 0.
- in_valid = 0 produces a bubble: wb_valid = 0, wb_regwrite = 0.
- Minimum memory-op latency is 2 cycles: IDLE → BUSY → ready in the first BUSY cycle; wb is updated on the 3rd edge.
- Back-to-back memory ops: after the ready cycle, IDLE accepts the next op in the next cycle (one bubble between requests).

Test Plan:
- Reset pulse mid-BUSY (req high) -> next cycle dmem_req = 0, stall = 0, all wb_* = 0, state IDLE.
- Store SB, addr 0x103, data 0x000000A5, ready after 2 cycles -> dmem_addr = 0x100, be = 1000, wdata = 0xA5A5A5A5, we = 1, stall high 3 cycles, wb_regwrite = 0.
- Load LH, addr 0x202, rdata 0x8001_1234 -> be = 1100, wb_loaddata = 0xFFFF8001. Then LHU at the same address -> wb_loaddata = 0x00008001.
- LW at addr 0x206 -> misalign pulse, dmem_req never asserted, stall = 0, wb_valid = 1 with wb_regwrite = 0.
- Load LB at addr 0x301, ready never asserted, TIMEOUT_CYCLES = 4 -> bus_err pulses on the 4th BUSY cycle, req drops, stall released.
- ADD (regwrite = 1, rd = 7, alu = 0x55) followed by LW 0x400 with ready immediate, rdata 0xDEADBEEF -> wb for the ADD after 1 cycle; wb_loaddata = 0xDEADBEEF with wb_rd matching the LW.
